// File: rtl/filter_pkg.sv
// Shared types and defaults for the two-lane pixel filter join.
package filter_pkg;

  typedef enum logic [1:0] {
    MODE_A   = 2'd0,
    MODE_B   = 2'd1,
    MODE_AVG = 2'd2,
    MODE_MAX = 2'd3
  } join_mode_e;

  localparam int DEFAULT_BITS = 8;
  localparam int FRAME_PIXELS = 76800;

endpackage

// File: rtl/filter_stream_join_if.sv
// Bundle of both input lanes, the mode select and the joined output stream.
interface filter_stream_join_if #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) ();
    localparam int SW = $clog2(DEPTH) + 1;

    // Every stream moves a beat on a rising clk edge where valid && ready are
    // both high; valid never waits on ready, and ready may depend on state only.
    logic [BITS-1:0] pix_a;
    logic            valid_a;
    logic            ready_a;
    logic [BITS-1:0] pix_b;
    logic            valid_b;
    logic            ready_b;
    logic [1:0]      mode;
    logic [BITS-1:0] pix_out;
    logic            valid_out;
    logic            eop_out;
    logic            output_ready;
    logic [SW-1:0]   skew;

    modport slave (
        input  pix_a, valid_a, pix_b, valid_b, mode, output_ready,
        output ready_a, ready_b, pix_out, valid_out, eop_out, skew
    );

    modport master (
        output pix_a, valid_a, pix_b, valid_b, mode, output_ready,
        input  ready_a, ready_b, pix_out, valid_out, eop_out, skew
    );
endinterface

// File: rtl/pix_fifo.sv
// Per-lane pixel FIFO with registered occupancy; the head is only visible
// the cycle after it was written (no fall-through).
module pix_fifo #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [BITS-1:0]          push_data,
    input  logic                     pop,
    output logic [BITS-1:0]          pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Guards keep occupancy consistent even if a caller misbehaves.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
endmodule

// File: rtl/filter_stream_join.sv
// Joins the threshold (A) and brightness (B) lanes into one registered stream,
// popping both lane FIFOs in lockstep and marking the last pixel of each frame.
module filter_stream_join
    import filter_pkg::*;
#(
    parameter int BITS         = DEFAULT_BITS,
    parameter int DEPTH        = 4,
    parameter int FRAME_PIXELS = filter_pkg::FRAME_PIXELS
) (
    input  logic                  clk,
    input  logic                  reset,
    filter_stream_join_if.slave   bus,
    output logic                  dbg_state
);
    localparam int SW = $clog2(DEPTH) + 1;
    localparam int FW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [FW-1:0] LAST_PIX = FW'(FRAME_PIXELS - 1);

    localparam logic [0:0] OUT_EMPTY = 1'b0;
    localparam logic [0:0] OUT_FULL  = 1'b1;

    logic [BITS-1:0] head_a;
    logic [BITS-1:0] head_b;
    logic [SW-1:0]   count_a;
    logic [SW-1:0]   count_b;
    logic            full_a;
    logic            full_b;
    logic            empty_a;
    logic            empty_b;
    logic            push_a;
    logic            push_b;
    logic            pair_avail;
    logic            pop;

    logic [0:0]      state;
    logic [FW-1:0]   frame_cnt;
    logic [BITS-1:0] comb_pix;
    logic [BITS:0]   sum;
    logic [SW-1:0]   occ_diff;
    join_mode_e      mode_sel;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign bus.ready_a = reset && !full_a;
    assign bus.ready_b = reset && !full_b;
    assign push_a      = bus.valid_a && bus.ready_a;
    assign push_b      = bus.valid_b && bus.ready_b;

    pix_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .reset     (reset),
        .push      (push_a),
        .push_data (bus.pix_a),
        .pop       (pop),
        .pop_data  (head_a),
        .count     (count_a),
        .full      (full_a),
        .empty     (empty_a)
    );

    pix_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .reset     (reset),
        .push      (push_b),
        .push_data (bus.pix_b),
        .pop       (pop),
        .pop_data  (head_b),
        .count     (count_b),
        .full      (full_b),
        .empty     (empty_b)
    );

    assign pair_avail = !empty_a && !empty_b;
    assign pop        = pair_avail && (state == OUT_EMPTY || bus.output_ready);

    assign mode_sel = join_mode_e'(bus.mode);
    assign sum      = {1'b0, head_a} + {1'b0, head_b};

    always_comb begin
        comb_pix = head_a;
        case (mode_sel)
            MODE_A:   comb_pix = head_a;
            MODE_B:   comb_pix = head_b;
            MODE_AVG: comb_pix = sum[BITS:1];
            MODE_MAX: comb_pix = (head_a > head_b) ? head_a : head_b;
            default:  comb_pix = head_a;
        endcase
    end

    assign occ_diff = (count_a >= count_b) ? (count_a - count_b) : (count_b - count_a);

    // Output stage: a pop always (re)loads it; a drain without a pop empties it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= OUT_EMPTY;
            bus.pix_out <= '0;
            bus.eop_out <= 1'b0;
            frame_cnt   <= '0;
            bus.skew    <= '0;
        end else begin
            bus.skew <= occ_diff;
            if (pop) begin
                state       <= OUT_FULL;
                bus.pix_out <= comb_pix;
                bus.eop_out <= (frame_cnt == LAST_PIX);
                frame_cnt   <= (frame_cnt == LAST_PIX) ? '0 : frame_cnt + FW'(1);
            end else if (state == OUT_FULL && bus.output_ready) begin
                state <= OUT_EMPTY;
            end
        end
    end

    assign bus.valid_out = (state == OUT_FULL);
    assign dbg_state     = state;
endmodule

// File: tb/tb_filter_stream_join.sv
// Directed bench for filter_stream_join: vector table for the combine modes
// plus hand sequences for latency, backpressure, stall, framing and reset.
module tb_filter_stream_join;
  import filter_pkg::*;

  localparam int BITS  = 8;
  localparam int DEPTH = 4;
  localparam int FP    = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dbg_state;

  always #5 clk = ~clk;

  filter_stream_join_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();

  filter_stream_join #(.BITS(BITS), .DEPTH(DEPTH), .FRAME_PIXELS(FP)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    logic [7:0] exp_pix;
  } vec_t;

  vec_t vecs [8];

  int errors = 0;
  int checks = 0;
  logic [BITS:0] exp_q[$];
  logic [BITS-1:0] qa[$];
  logic [BITS-1:0] qb[$];
  int eop_log[$];
  int fcnt = 0;
  int cur_mode = 0;
  int out_cnt = 0;
  logic [BITS-1:0] last_pix;
  logic acc_a, acc_b;
  logic [7:0] a_next, b_next;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] model_pix(input int m, input logic [7:0] a, input logic [7:0] b);
    int s;
    case (m)
      0: return a;
      1: return b;
      2: begin
        s = (int'(a) + int'(b)) / 2;
        return s[7:0];
      end
      default: return (a > b) ? a : b;
    endcase
  endfunction

  task automatic model_pair();
    logic [7:0] a, b, p;
    logic e;
    while (qa.size() > 0 && qb.size() > 0) begin
      a = qa.pop_front();
      b = qb.pop_front();
      p = model_pix(cur_mode, a, b);
      e = (fcnt == FP - 1);
      fcnt = e ? 0 : fcnt + 1;
      exp_q.push_back({e, p});
    end
  endtask

  // One clock: drive, sample at negedge, let the edge happen, update model.
  task automatic step(input logic va, input logic [7:0] a, input logic vb, input logic [7:0] b,
                      input logic ordy);
    logic [BITS:0] exp;
    bus.valid_a = va;
    bus.pix_a = a;
    bus.valid_b = vb;
    bus.pix_b = b;
    bus.output_ready = ordy;
    @(negedge clk);
    acc_a = va && bus.ready_a;
    acc_b = vb && bus.ready_b;
    if (bus.valid_out && ordy) begin
      out_cnt++;
      last_pix = bus.pix_out;
      if (bus.eop_out) eop_log.push_back(out_cnt);
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        check("sb_out", {bus.eop_out, bus.pix_out}, exp);
      end
    end
    @(posedge clk);
    #1;
    if (acc_a) qa.push_back(a);
    if (acc_b) qb.push_back(b);
    model_pair();
    bus.valid_a = 1'b0;
    bus.valid_b = 1'b0;
  endtask

  task automatic stream(input int n, input logic ordy);
    for (int i = 0; i < n; i++) begin
      step(1'b1, a_next, 1'b1, b_next, ordy);
      if (acc_a) a_next++;
      if (acc_b) b_next++;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic set_mode(input int m);
    cur_mode = m;
    bus.mode = m[1:0];
  endtask

  initial begin
    int a_idx, b_idx, base, held_bad;
    logic [7:0] held;

    vecs[0] = '{8'hF0, 8'h0F, 2'd0, 8'hF0};
    vecs[1] = '{8'hF0, 8'h0F, 2'd1, 8'h0F};
    vecs[2] = '{8'hF0, 8'h0F, 2'd2, 8'h7F};
    vecs[3] = '{8'hF0, 8'h0F, 2'd3, 8'hF0};
    vecs[4] = '{8'hFF, 8'hFF, 2'd2, 8'hFF};
    vecs[5] = '{8'h0F, 8'hF0, 2'd3, 8'hF0};
    vecs[6] = '{8'h01, 8'h02, 2'd2, 8'h01};
    vecs[7] = '{8'h00, 8'h00, 2'd3, 8'h00};

    bus.pix_a = '0; bus.valid_a = 1'b0;
    bus.pix_b = '0; bus.valid_b = 1'b0;
    bus.mode = 2'd0; bus.output_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_a", bus.ready_a, 0);
    check("rst_ready_b", bus.ready_b, 0);
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_eop_out", bus.eop_out, 0);
    check("rst_pix_out", bus.pix_out, 0);
    check("rst_skew", bus.skew, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    #1;
    check("rel_ready_a", bus.ready_a, 1);
    check("rel_ready_b", bus.ready_b, 1);

    // Latency: transfer at edge N, valid_out only after edge N+1
    set_mode(2);
    step(1'b1, 8'h33, 1'b1, 8'h11, 1'b1);
    check("lat_edge_n", bus.valid_out, 0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("lat_edge_n1", bus.valid_out, 1);
    check("lat_pix", bus.pix_out, 8'h22);
    drain();

    // Lockstep stream, one output per cycle
    base = out_cnt;
    for (int i = 0; i < 16; i++) step(1'b1, 8'h10 + 8'(i), 1'b1, 8'h10 + 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("lockstep_count", out_cnt - base, 16);
    check("lockstep_last", last_pix, 8'h1F);
    drain();

    // Combine mode table
    for (int i = 0; i < 8; i++) begin
      set_mode(int'(vecs[i].mode));
      step(1'b1, vecs[i].a, 1'b1, vecs[i].b, 1'b1);
      drain();
      check($sformatf("mode_vec%0d", i), last_pix, vecs[i].exp_pix);
    end

    // Unbalanced lane: A fills and stalls, B catches up
    set_mode(0);
    a_idx = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h40 + 8'(a_idx), 1'b0, 8'h00, 1'b1);
      if (acc_a) a_idx++;
      if (i == 3) check("ready_a_full", bus.ready_a, 0);
    end
    check("a_accepted", a_idx, 4);
    check("skew_full", bus.skew, 4);
    check("no_out_unbalanced", bus.valid_out, 0);
    b_idx = 0;
    for (int k = 0; k < 20 && (a_idx < 6 || b_idx < 6); k++) begin
      step(a_idx < 6, 8'h40 + 8'(a_idx), b_idx < 6, 8'h80 + 8'(b_idx), 1'b1);
      if (acc_a) a_idx++;
      if (acc_b) b_idx++;
    end
    check("a_late_accept", a_idx, 6);
    drain();
    check("skew_balanced", bus.skew, 0);

    // Output stall with both lanes streaming
    set_mode(3);
    a_next = 8'h20;
    b_next = 8'h60;
    stream(1, 1'b0);
    held = 8'h00;
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      stream(1, 1'b0);
      if (i == 0) held = bus.pix_out;
      else if (bus.pix_out != held) held_bad++;
    end
    check("stall_hold", held_bad, 0);
    check("stall_pix", held, 8'h60);
    check("stall_ready_a", bus.ready_a, 0);
    check("stall_ready_b", bus.ready_b, 0);
    check("stall_state", dbg_state, 1);
    check("stall_accepted", a_next - 8'h20, 5);
    stream(6, 1'b1);
    drain();

    // Reset mid-frame with partially filled FIFOs
    set_mode(1);
    stream(5, 1'b1);
    drain();
    stream(3, 1'b0);
    step(1'b1, a_next, 1'b0, 8'h00, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", bus.valid_out, 0);
    check("mid_rst_skew", bus.skew, 0);
    check("mid_rst_ready_a", bus.ready_a, 0);
    check("mid_rst_ready_b", bus.ready_b, 0);
    check("mid_rst_pix", bus.pix_out, 0);
    qa.delete();
    qb.delete();
    exp_q.delete();
    fcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rel_ready_a", bus.ready_a, 1);

    // Frame marking after reset: eop on outputs 8 and 16 only
    eop_log.delete();
    base = out_cnt;
    stream(20, 1'b1);
    drain();
    check("frame_outputs", out_cnt - base, 20);
    check("frame_eop_count", eop_log.size(), 2);
    if (eop_log.size() == 2) begin
      check("frame_eop_first", eop_log[0] - base, FP);
      check("frame_eop_second", eop_log[1] - base, 2 * FP);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/filter_stream_join.md
# filter_stream_join

Receiver-side join for the two parallel pixel-filter lanes (threshold lane A, brightness lane B). It accepts both `pix_out`/`valid_out` streams with per-lane backpressure, buffers each lane in a small FIFO, and pops them in lockstep pairs. Each pair is combined per a selectable mode into a single registered output stream with frame-boundary marking. It sits directly downstream of the filter pair and drives their shared `output_ready`.

## Interface
- BITS, 8, pixel width
- DEPTH, 4, per-lane FIFO depth (power of 2, ≥2)
- FRAME_PIXELS, 76800, pixels per frame for end-of-frame marking
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_a  in  BITS  lane A pixel (threshold filter)
- valid_a  in  1  lane A pixel valid
- ready_a  out  1  lane A may transfer (FIFO A not full)
- pix_b  in  BITS  lane B pixel (brightness filter)
- valid_b  in  1  lane B pixel valid
- ready_b  out  1  lane B may transfer (FIFO B not full)
- mode  in  2  combine select: 0 pass A, 1 pass B, 2 average, 3 max
- pix_out  out  BITS  combined pixel
- valid_out  out  1  pix_out valid
- eop_out  out  1  marks last pixel of frame, qualified by valid_out
- output_ready  in  1  downstream accepts
- skew  out  $clog2(DEPTH)+1  |occupancy A − occupancy B|, registered

## Operation
- Transfer on a lane when valid && ready. Each transfer writes its pixel into that lane's FIFO.
- ready_a = !full_a and ready_b = !full_b, both combinational from registered occupancy. No push-when-full is possible.
- Pair available = !empty_a && !empty_b.
- Pop both FIFOs on the same edge when the pair is available and the output stage is empty or being drained (!valid_out || output_ready).
- `mode` is sampled at pop time.
- Combine rules:
  - pass A: a
  - pass B: b
  - average: (a+b)>>1, using a BITS+1-bit sum, truncated
  - max: larger of a and b
- Frame counter 0..FRAME_PIXELS−1 increments on every pop and wraps to 0. eop_out = 1 on the popped pair whose count was FRAME_PIXELS−1.
- Output stage states:
  - EMPTY: valid_out=0.
  - FULL: pix_out and eop_out are held stable until output_ready.
  - FULL and output_ready with a pair available: reload the stage, stay FULL.
  - FULL and output_ready with no pair: go to EMPTY.
- Simultaneous push and pop on a lane leaves occupancy unchanged. A push into an empty FIFO is not visible to pop until the next cycle (no fall-through).
- An unbalanced lane fills to DEPTH and then stalls itself via ready. The other lane keeps flowing until the pair pops.
- Reset (asserted anytime, including mid-frame) clears:
  - FIFO pointers and occupancies
  - frame counter and skew
  - valid_out, eop_out, pix_out (all to 0)
  - In-flight pixels are discarded.
- After reset deassertion ready_a = ready_b = 1.

## Timing
- Latency: the later of the two lane transfers occurs at edge N. valid_out rises after edge N+1, provided the output stage is free.
- Throughput: one pixel per cycle sustained when both lanes are valid every cycle and output_ready=1.
- ready_a/ready_b fall in the cycle after the push that fills the FIFO, and rise in the cycle after a pop from a full FIFO.
- skew updates one cycle after an occupancy change.
- Reset values: ready_a=ready_b=0 while reset is asserted, valid_out=0, eop_out=0, pix_out=0, skew=0.

## Structure
- Package `filter_pkg` holds:
  - the `join_mode_e` enum (MODE_A, MODE_B, MODE_AVG, MODE_MAX)
  - default BITS
  - FRAME_PIXELS constant
- Sub-module `pix_fifo` (parameters BITS, DEPTH) provides registered occupancy plus full/empty. It is instantiated once per lane.
- The top module contains pop control, combine logic, frame counter, skew register and the output stage.

## Test plan
- Lockstep stream: both lanes feed 0x10..0x1F every cycle, mode=2, output_ready=1 → outputs equal input values in order, first valid_out two cycles after first transfer, one per cycle.
- Mode check: a=0xF0, b=0x0F → mode0 0xF0, mode1 0x0F, mode2 0x7F, mode3 0xF0. Also a=b=0xFF, mode2 → 0xFF (no overflow).
- Skew/backpressure: DEPTH=4, lane A sends 6 pixels while lane B is idle → ready_a low after 4th push, skew=4, no output. Then B sends 4 → 4 outputs in order, and A's 5th/6th pixels are accepted after pops.
- Output stall: output_ready=0 for 10 cycles with both lanes streaming → pix_out held constant, both FIFOs fill, ready_a=ready_b=0. On release, no pixel is lost or duplicated.
- Frame marking: FRAME_PIXELS=8, stream 20 pairs → eop_out on outputs 8 and 16 only, counter wraps.
- Reset mid-frame: assert reset after 5 pixels with FIFOs half full → valid_out=0, skew=0, ready low during reset. After release the next pair produces eop_out on output FRAME_PIXELS.
